// File: rtl/mem_arb_pkg.sv
// Shared constants for the I/D memory arbiter: bus widths, the starvation
// limit default and the arbiter state encoding.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive D-side grants made while the I-side is waiting, so the
// arbiter can hand the port to I once the limit is reached.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_i,
  input  logic grant_d,
  input  logic i_pending,
  output logic at_limit
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  // A D grant with nobody waiting on the I side ends the starvation run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (!i_pending) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign at_limit = (starve_cnt == LIMIT);

endmodule

// File: rtl/mem_arb.sv
// Two-requester (instruction fetch / load-store) arbiter in front of a single
// memory port, D-side priority with bounded I-side starvation.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,

  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [STRB_W-1:0] d_req_we,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [STRB_W-1:0] mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              stall,
  output logic              owner_d
);

  state_t state;
  logic   idle;
  logic   at_limit;
  logic   grant_i;
  logic   grant_d;
  logic   resp_take;

  assign idle      = (state == ST_IDLE);
  assign grant_d   = idle & d_req_valid & ~(i_req_valid & at_limit);
  assign grant_i   = idle & i_req_valid & ~grant_d;
  assign resp_take = (state == ST_WAIT) & mem_resp_valid;

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .grant_i  (grant_i),
    .grant_d  (grant_d),
    .i_pending(i_req_valid),
    .at_limit (at_limit)
  );

  // Handshakes outside their own state are ignored, so stray ready/response
  // pulses never advance the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (grant_i | grant_d) state <= ST_ISSUE;
        ST_ISSUE: if (mem_req_ready)     state <= ST_WAIT;
        ST_WAIT:  if (mem_resp_valid)    state <= ST_IDLE;
        default:                         state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
      owner_d   <= 1'b0;
    end else if (grant_d) begin
      mem_addr  <= d_req_addr;
      mem_we    <= d_req_we;
      mem_wdata <= d_req_wdata;
      owner_d   <= 1'b1;
    end else if (grant_i) begin
      mem_addr  <= i_req_addr;
      mem_we    <= '0;
      mem_wdata <= '0;
      owner_d   <= 1'b0;
    end
  end

  // Response data is registered so each requester sees a clean one-cycle pulse
  // and its data word holds until its next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      i_resp_data  <= '0;
      d_resp_data  <= '0;
    end else begin
      i_resp_valid <= resp_take & ~owner_d;
      d_resp_valid <= resp_take & owner_d;
      if (resp_take & ~owner_d) i_resp_data <= mem_rdata;
      if (resp_take & owner_d)  d_resp_data <= mem_rdata;
    end
  end

  assign mem_req_valid = (state == ST_ISSUE);
  assign stall = (i_req_valid & ~i_resp_valid) | (d_req_valid & ~d_resp_valid);

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_mem_arb;

  localparam int LIMIT = 4;

  localparam int BUS_FREE     = 0;
  localparam int BUS_OFFERED  = 1;
  localparam int BUS_ACCEPTED = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic [3:0]  d_req_we;
  logic [31:0] d_req_wdata;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        owner_d;

  mem_arb #(
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .i_req_addr    (i_req_addr),
    .i_resp_valid  (i_resp_valid),
    .i_resp_data   (i_resp_data),
    .d_req_valid   (d_req_valid),
    .d_req_addr    (d_req_addr),
    .d_req_we      (d_req_we),
    .d_req_wdata   (d_req_wdata),
    .d_resp_valid  (d_resp_valid),
    .d_resp_data   (d_resp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .owner_d       (owner_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [3:0]  dwe;
    logic [31:0] dwd;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        e_mrv;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata;
    logic        e_own;
    logic        e_irv;
    logic        e_drv;
    logic [31:0] e_idata;
    logic [31:0] e_ddata;
    logic        e_stall;
  } vec_t;

  typedef struct {
    logic        d;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } txn_t;

  vec_t vecs[12];

  // Transaction-level reference model state
  int          phase;
  int          starve;
  txn_t        cur;
  logic        exp_irv;
  logic        exp_drv;
  logic [31:0] last_i;
  logic [31:0] last_d;

  task automatic check_word(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, actual, expected);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b, want %b", name, $time, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic [31:0] ia, input logic dv,
                                input logic [31:0] da, input logic [3:0] dwe, input logic [31:0] dwd,
                                input logic rdy, input logic rv, input logic [31:0] rd);
    i_req_valid    = iv;
    i_req_addr     = ia;
    d_req_valid    = dv;
    d_req_addr     = da;
    d_req_we       = dwe;
    d_req_wdata    = dwd;
    mem_req_ready  = rdy;
    mem_resp_valid = rv;
    mem_rdata      = rd;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    check_word({tag, "_mem_addr"}, mem_addr, 32'h0);
    check_word({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check_word({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check_bit({tag, "_i_resp_valid"}, i_resp_valid, 1'b0);
    check_bit({tag, "_d_resp_valid"}, d_resp_valid, 1'b0);
    check_word({tag, "_i_resp_data"}, i_resp_data, 32'h0);
    check_word({tag, "_d_resp_data"}, d_resp_data, 32'h0);
    check_bit({tag, "_owner_d"}, owner_d, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic model_reset();
    phase   = BUS_FREE;
    starve  = 0;
    exp_irv = 1'b0;
    exp_drv = 1'b0;
    last_i  = 32'h0;
    last_d  = 32'h0;
  endtask

  // Called just after a rising edge, with the inputs that edge sampled.
  task automatic model_edge();
    exp_irv = 1'b0;
    exp_drv = 1'b0;
    case (phase)
      BUS_FREE: begin
        if (d_req_valid && !(i_req_valid && starve == LIMIT)) begin
          cur    = '{1'b1, d_req_addr, d_req_we, d_req_wdata};
          starve = i_req_valid ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
          phase  = BUS_OFFERED;
        end else if (i_req_valid) begin
          cur    = '{1'b0, i_req_addr, 4'h0, 32'h0};
          starve = 0;
          phase  = BUS_OFFERED;
        end
      end
      BUS_OFFERED: if (mem_req_ready) phase = BUS_ACCEPTED;
      BUS_ACCEPTED: begin
        if (mem_resp_valid) begin
          if (cur.d) begin
            exp_drv = 1'b1;
            last_d  = mem_rdata;
          end else begin
            exp_irv = 1'b1;
            last_i  = mem_rdata;
          end
          phase = BUS_FREE;
        end
      end
      default: phase = BUS_FREE;
    endcase
  endtask

  task automatic check_output();
    check_bit("rnd_i_resp_valid", i_resp_valid, exp_irv);
    check_bit("rnd_d_resp_valid", d_resp_valid, exp_drv);
    check_word("rnd_i_resp_data", i_resp_data, last_i);
    check_word("rnd_d_resp_data", d_resp_data, last_d);
    check_bit("rnd_mem_req_valid", mem_req_valid, phase == BUS_OFFERED);
    if (phase == BUS_OFFERED) begin
      check_word("rnd_mem_addr", mem_addr, cur.addr);
      check_word("rnd_mem_we", 32'(mem_we), 32'(cur.we));
      check_bit("rnd_owner_d", owner_d, cur.d);
      if (cur.d) check_word("rnd_mem_wdata", mem_wdata, cur.wdata);
    end
    check_bit("rnd_stall", stall, (i_req_valid & ~exp_irv) | (d_req_valid & ~exp_drv));
  endtask

  // Requesters hold until their response; occasionally one gives up early.
  task automatic drive_random();
    if (exp_irv || !i_req_valid) begin
      i_req_valid = ($urandom_range(0, 2) != 0);
      i_req_addr  = $urandom & 32'hFFFF_FFFC;
    end else if ($urandom_range(0, 31) == 0) begin
      i_req_valid = 1'b0;
    end
    if (exp_drv || !d_req_valid) begin
      d_req_valid = ($urandom_range(0, 7) != 0);
      d_req_addr  = $urandom;
      d_req_we    = 4'($urandom_range(0, 15));
      d_req_wdata = $urandom;
    end else if ($urandom_range(0, 31) == 0) begin
      d_req_valid = 1'b0;
    end
    mem_req_ready  = (phase == BUS_OFFERED)  ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
    mem_resp_valid = (phase == BUS_ACCEPTED) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
    mem_rdata      = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout at %0t, want normal completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic exp_grants[10];
    int   n;

    // Directed table: single I fetch, D-before-I contention, stray handshakes in IDLE.
    vecs[0]  = '{1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                 1'b1, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
    vecs[1]  = '{1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
    vecs[2]  = '{1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF,
                 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h100, 1'b1, 32'h200, 4'h3, 32'h1234_5678, 1'b0, 1'b0, 32'h0,
                 1'b1, 32'h200, 4'h3, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1};
    vecs[5]  = '{1'b1, 32'h100, 1'b1, 32'h200, 4'h3, 32'h1234_5678, 1'b1, 1'b0, 32'h0,
                 1'b0, 32'h200, 4'h3, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h100, 1'b1, 32'h200, 4'h3, 32'h1234_5678, 1'b0, 1'b1, 32'hAA,
                 1'b0, 32'h200, 4'h3, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hAA, 1'b1};
    vecs[7]  = '{1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                 1'b1, 32'h100, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hAA, 1'b1};
    vecs[8]  = '{1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                 1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hAA, 1'b1};
    vecs[9]  = '{1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001,
                 1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 32'hAA, 1'b0};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hBAD,
                 1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 32'hAA, 1'b0};
    vecs[11] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                 1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 32'hAA, 1'b0};

    exp_grants = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    $display("[TB] reset and directed vectors");
    rst = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check_bit("reset_stall", stall, 1'b0);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      apply_stimulus(vecs[k].iv, vecs[k].ia, vecs[k].dv, vecs[k].da, vecs[k].dwe,
                     vecs[k].dwd, vecs[k].rdy, vecs[k].rv, vecs[k].rd);
      @(negedge clk);
      check_bit($sformatf("vec%0d_mem_req_valid", k), mem_req_valid, vecs[k].e_mrv);
      check_word($sformatf("vec%0d_mem_addr", k), mem_addr, vecs[k].e_addr);
      check_word($sformatf("vec%0d_mem_we", k), 32'(mem_we), 32'(vecs[k].e_we));
      if (vecs[k].e_own) check_word($sformatf("vec%0d_mem_wdata", k), mem_wdata, vecs[k].e_wdata);
      check_bit($sformatf("vec%0d_owner_d", k), owner_d, vecs[k].e_own);
      check_bit($sformatf("vec%0d_i_resp_valid", k), i_resp_valid, vecs[k].e_irv);
      check_bit($sformatf("vec%0d_d_resp_valid", k), d_resp_valid, vecs[k].e_drv);
      check_word($sformatf("vec%0d_i_resp_data", k), i_resp_data, vecs[k].e_idata);
      check_word($sformatf("vec%0d_d_resp_data", k), d_resp_data, vecs[k].e_ddata);
      check_bit($sformatf("vec%0d_stall", k), stall, vecs[k].e_stall);
    end

    $display("[TB] ready held low for five cycles");
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h300, 4'hF, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_bit("hold_mem_req_valid", mem_req_valid, 1'b1);
      check_word("hold_mem_addr", mem_addr, 32'h300);
      check_word("hold_mem_we", 32'(mem_we), 32'hF);
      check_word("hold_mem_wdata", mem_wdata, 32'hA5A5_5A5A);
      check_bit("hold_d_resp_valid", d_resp_valid, 1'b0);
      check_bit("hold_i_resp_valid", i_resp_valid, 1'b0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1111_2222;
    @(negedge clk);
    check_bit("hold_done_d_resp_valid", d_resp_valid, 1'b1);
    check_word("hold_done_d_resp_data", d_resp_data, 32'h1111_2222);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);

    $display("[TB] reset during WAIT, late response afterwards");
    apply_stimulus(1'b1, 32'h500, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check_word("wait_mem_addr", mem_addr, 32'h500);
    check_bit("wait_mem_req_valid", mem_req_valid, 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_0000);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_bit("stray_i_resp_valid", i_resp_valid, 1'b0);
      check_bit("stray_d_resp_valid", d_resp_valid, 1'b0);
      check_bit("stray_mem_req_valid", mem_req_valid, 1'b0);
      check_word("stray_i_resp_data", i_resp_data, 32'h0);
    end
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h800, 4'h1, 32'h55, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_bit("post_rst_mem_req_valid", mem_req_valid, 1'b1);
    check_word("post_rst_mem_addr", mem_addr, 32'h800);

    $display("[TB] starvation grant order");
    do_reset();
    apply_stimulus(1'b1, 32'h600, 1'b1, 32'h700, 4'h0, 32'h0, 1'b1, 1'b1, 32'h7777_0000);
    n = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        check_bit($sformatf("starve_grant%0d_owner_d", n), owner_d, exp_grants[n]);
        n++;
      end
    end
    check_word("starve_grant_count", 32'(n), 32'd10);

    $display("[TB] randomized run against reference model");
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_output();
      drive_random();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
